// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (RTS, 11-bit frame, ACK check).
// Optional watchdog over SEND/ACK is enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;
    state_t        state_q;
    logic [2:0]    clk_sync_q;
    logic [2:0]    data_sync_q;
    logic [9:0]    sh_q;
    logic [3:0]    bitcnt_q;
    logic [IW-1:0] inh_q;
    logic          fall;
    logic          timeout;
    assign fall = clk_sync_q[2] & ~clk_sync_q[1];
`ifdef PS2_HOST_TX_TIMEOUT_EN
    logic [19:0] tmo_q;
    assign timeout = (state_q == SEND || state_q == ACK) && tmo_q == 20'(TIMEOUT_CYCLES - 1);
    // Watchdog counts only while waiting on device clock edges; cleared everywhere else (incl. RTS).
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) tmo_q <= '0;
        else       tmo_q <= (state_q == SEND || state_q == ACK) ? tmo_q + 20'd1 : '0;
`else
    assign timeout = 1'b0;
`endif
    // Three-flop synchronisers for the asynchronous pad values; idle lines read as high.
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
        end
    // Transfer FSM with registered line drivers and status outputs.
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            state_q     <= IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            sh_q        <= '0;
            bitcnt_q    <= '0;
            inh_q       <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (timeout) begin
                state_q     <= WAIT_IDLE;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_err      <= 1'b1;
            end else case (state_q)
                IDLE: if (tx_valid) begin
                    state_q    <= INHIBIT;
                    tx_ready   <= 1'b0;
                    busy       <= 1'b1;
                    ps2_clk_oe <= 1'b1;
                    sh_q       <= {1'b1, ~^tx_data, tx_data};
                    bitcnt_q   <= '0;
                    inh_q      <= '0;
                end
                INHIBIT: if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    state_q     <= RTS;
                    ps2_data_oe <= 1'b1;
                end else inh_q <= inh_q + 1'b1;
                RTS: begin
                    state_q    <= SEND;
                    ps2_clk_oe <= 1'b0;
                end
                SEND: if (fall) begin
                    ps2_data_oe <= ~sh_q[0];
                    sh_q        <= sh_q >> 1;
                    bitcnt_q    <= bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) state_q <= ACK;
                end
                ACK: if (fall) begin
                    tx_done <= ~data_sync_q[2];
                    tx_err  <= data_sync_q[2];
                    state_q <= WAIT_IDLE;
                end
                WAIT_IDLE: if (clk_sync_q[2] & data_sync_q[2]) begin
                    state_q  <= IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a behavioural PS/2 device clocking at a 40-cycle period.
module tb_ps2_host_tx;
    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        dev_clk_low = 1'b0;
    logic        dev_data_low = 1'b0;
    logic        tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic        ps2_clk, ps2_data;
    logic [10:0] bits;
    int          n_cmp = 0, n_bad = 0;
    int          done_cnt = 0, err_cnt = 0, oe_cnt = 0, ovl_cnt = 0;
    int          d0, e0, o0, v0, n;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
        .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (ps2_clk_oe) oe_cnt++;
        if (ps2_clk_oe && ps2_data_oe) ovl_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d, input logic hold);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = hold;
        check_eq("accept_clk_oe", ps2_clk_oe, 1);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!tx_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, tx_ready, 1);
    endtask

    // Device: waits for RTS release, then samples data late in each high phase and drops the clock.
    task automatic dev_xfer(input int nfall, input logic ack, output logic [10:0] got);
        int k = 0;
        got = '0;
        while (ps2_clk_oe && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            check_eq("rts_release_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < nfall; i++) begin
            repeat (10) @(negedge clk);
            got[i] = ps2_data;
            repeat (5) @(negedge clk);
            if (i == 10 && ack) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_clk_oe", ps2_clk_oe, 0);
        check_eq("rst_data_oe", ps2_data_oe, 0);
        check_eq("rst_pulses", {tx_done, tx_err}, 0);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 0xED acknowledged
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED, 1'b0);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_ready_low", tx_ready, 0);
        dev_xfer(11, 1'b1, bits);
        wait_ready("t1_ready");
        check_eq("t1_frame", bits, 11'b1_1_11101101_0);
        check_eq("t1_done", done_cnt - d0, 1);
        check_eq("t1_err", err_cnt - e0, 0);

        // 2: 0x00, clock inhibit length and start bit
        d0 = done_cnt; o0 = oe_cnt; v0 = ovl_cnt;
        start_tx(8'h00, 1'b0);
        dev_xfer(11, 1'b1, bits);
        wait_ready("t2_ready");
        check_eq("t2_frame", bits, 11'b1_1_00000000_0);
        check_eq("t2_start", bits[0], 0);
        check_eq("t2_parity", bits[9], 1);
        check_eq("t2_clk_oe_len", oe_cnt - o0, 21);
        check_eq("t2_overlap", ovl_cnt - v0, 1);
        check_eq("t2_done", done_cnt - d0, 1);

        // 3: no ACK from device
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h3C, 1'b0);
        dev_xfer(11, 1'b0, bits);
        wait_ready("t3_ready");
        check_eq("t3_frame", bits, 11'b1_1_00111100_0);
        check_eq("t3_err", err_cnt - e0, 1);
        check_eq("t3_done", done_cnt - d0, 0);

        // 4: device never clocks
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF0, 1'b0);
        n = 0;
        while (ps2_clk_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_rts_release", ps2_clk_oe, 0);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        n = 0;
        while (!tx_err && n < 2500) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_err_window", (n >= 1998 && n <= 2003), 1);
        check_eq("t4_clk_oe", ps2_clk_oe, 0);
        check_eq("t4_data_oe", ps2_data_oe, 0);
        check_eq("t4_err", err_cnt - e0, 1);
        wait_ready("t4_ready");
`else
        repeat (3000) @(negedge clk);
        check_eq("t4_busy_hang", busy, 1);
        check_eq("t4_no_err", err_cnt - e0, 0);
        clrn = 1'b0;
        #1;
        check_eq("t4_rst_busy", busy, 0);
        @(negedge clk);
        clrn = 1'b1;
`endif
        check_eq("t4_done", done_cnt - d0, 0);

        // 5: reset after the 5th data bit, then 0xFF completes
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h55, 1'b0);
        dev_xfer(6, 1'b0, bits);
        check_eq("t5_pre_rst_data_oe", ps2_data_oe, 1);
        #2;
        clrn = 1'b0;
        #1;
        check_eq("t5_rst_clk_oe", ps2_clk_oe, 0);
        check_eq("t5_rst_data_oe", ps2_data_oe, 0);
        check_eq("t5_rst_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t5_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        start_tx(8'hFF, 1'b0);
        dev_xfer(11, 1'b1, bits);
        wait_ready("t5_ready");
        check_eq("t5_frame", bits, 11'b1_1_11111111_0);
        check_eq("t5_done", done_cnt - d0, 1);

        // 6: tx_valid held with 0xAA during 0xF4
        d0 = done_cnt;
        start_tx(8'hF4, 1'b1);
        tx_data = 8'hAA;
        dev_xfer(11, 1'b1, bits);
        check_eq("t6_frame_f4", bits, 11'b1_0_11110100_0);
        check_eq("t6_done_f4", done_cnt - d0, 1);
        wait_ready("t6_ready");
        @(negedge clk);
        check_eq("t6_accept_aa", busy, 1);
        tx_valid = 1'b0;
        dev_xfer(11, 1'b1, bits);
        wait_ready("t6_ready_end");
        check_eq("t6_frame_aa", bits, 11'b1_1_10101010_0);
        check_eq("t6_done_total", done_cnt - d0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
